// File: rtl/aux_reply_decoder.sv
`default_nettype none
// ============================================================================
// Module      : aux_reply_decoder
// Description : Receive-side AUX reply stage. Collects PHY reply bytes at
//               line rate, decodes the reply header (ACK/NACK/DEFER) and
//               replays the reply as a 1-cycle ack strobe followed by a
//               gap-free data-byte burst.
//               Optional build macro AUX_REPLY_PAD_CHECK_EN: when defined,
//               a non-zero header low nibble makes the reply illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module aux_reply_decoder #(
  parameter int MAX_DATA = 16,
  parameter int CW       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ctrl_tr_vld,
  input  logic       ctrl_i2c_native,
  input  logic [7:0] phy_rx_byte,
  input  logic       phy_rx_vld,
  input  logic       phy_rx_done,
  input  logic       phy_rx_err,
  output logic [1:0] reply_ack,
  output logic       reply_ack_vld,
  output logic [7:0] reply_data,
  output logic       reply_data_vld,
  output logic       reply_error,
  output logic       reply_overrun
);

  localparam int AW = (MAX_DATA > 1) ? $clog2(MAX_DATA) : 1;

  // Header byte count plus a full data payload.
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_DATA + 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  // Only the bits that take part in decoding are stored for the header.
`ifdef AUX_REPLY_PAD_CHECK_EN
  localparam int HDR_LSB = 0;
`else
  localparam int HDR_LSB = 4;
`endif

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_COLLECT  = 3'd1;
  localparam logic [2:0] S_ACK_OUT  = 3'd2;
  localparam logic [2:0] S_DATA_OUT = 3'd3;
  localparam logic [2:0] S_DROP     = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [CW-1:0]      rx_cnt_q, rx_cnt_d;
  logic [CW-1:0]      tx_cnt_q, tx_cnt_d;
  logic [7:HDR_LSB]   hdr_q, hdr_d;
  logic               mode_i2c_q, mode_i2c_d;
  logic [7:0]         data_buf_q [MAX_DATA];
  logic [7:0]         data_buf_d [MAX_DATA];

  logic [1:0]         reply_ack_q, reply_ack_d;
  logic               reply_ack_vld_q, reply_ack_vld_d;
  logic [7:0]         reply_data_q, reply_data_d;
  logic               reply_data_vld_q, reply_data_vld_d;
  logic               reply_error_q, reply_error_d;
  logic               reply_overrun_q, reply_overrun_d;

  logic [7:HDR_LSB]   close_hdr;
  logic [1:0]         close_ack;
  logic               close_bad;
  logic               pad_bad;
  logic               do_close;

  // Header decode for the reply being closed: the incoming byte when the
  // header and the close arrive together in IDLE, otherwise the stored one.
  always_comb begin
    close_hdr = (state_q == S_IDLE) ? phy_rx_byte[7:HDR_LSB] : hdr_q;
    if (mode_i2c_q && (close_hdr[5:4] == 2'b00)) begin
      close_ack = close_hdr[7:6];
    end else begin
      close_ack = close_hdr[5:4];
    end
`ifdef AUX_REPLY_PAD_CHECK_EN
    pad_bad = |close_hdr[3:0];
`else
    pad_bad = 1'b0;
`endif
    close_bad = (close_ack == 2'b11) || pad_bad;
  end

  // Next-state, counter, buffer and registered-output computation.
  always_comb begin
    state_d          = state_q;
    rx_cnt_d         = rx_cnt_q;
    tx_cnt_d         = tx_cnt_q;
    hdr_d            = hdr_q;
    data_buf_d       = data_buf_q;
    mode_i2c_d       = ctrl_tr_vld ? ctrl_i2c_native : mode_i2c_q;
    reply_ack_d      = 2'b00;
    reply_ack_vld_d  = 1'b0;
    reply_data_d     = 8'h00;
    reply_data_vld_d = 1'b0;
    reply_overrun_d  = 1'b0;
    do_close         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (phy_rx_err) begin
          state_d = S_DROP;
        end else if (phy_rx_vld) begin
          hdr_d    = phy_rx_byte[7:HDR_LSB];
          rx_cnt_d = ONE_CNT;
          if (phy_rx_done) begin
            do_close = 1'b1;
          end else begin
            state_d = S_COLLECT;
          end
        end else if (phy_rx_done) begin
          // Reply closed without even a header byte.
          state_d = S_DROP;
        end
      end

      S_COLLECT: begin
        if (phy_rx_err) begin
          state_d = S_DROP;
        end else if (phy_rx_vld && (rx_cnt_q == FULL_CNT)) begin
          // One byte more than the buffer can replay.
          state_d = S_DROP;
        end else begin
          if (phy_rx_vld) begin
            data_buf_d[AW'(rx_cnt_q - ONE_CNT)] = phy_rx_byte;
            rx_cnt_d = rx_cnt_q + ONE_CNT;
          end
          if (phy_rx_done) begin
            do_close = 1'b1;
          end
        end
      end

      S_ACK_OUT: begin
        reply_overrun_d = phy_rx_vld || phy_rx_done;
        if (rx_cnt_q > ONE_CNT) begin
          state_d          = S_DATA_OUT;
          reply_data_d     = data_buf_q[0];
          reply_data_vld_d = 1'b1;
          tx_cnt_d         = ONE_CNT;
        end else begin
          state_d  = S_IDLE;
          rx_cnt_d = '0;
          tx_cnt_d = '0;
        end
      end

      S_DATA_OUT: begin
        reply_overrun_d = phy_rx_vld || phy_rx_done;
        if (tx_cnt_q == (rx_cnt_q - ONE_CNT)) begin
          state_d  = S_IDLE;
          rx_cnt_d = '0;
          tx_cnt_d = '0;
        end else begin
          reply_data_d     = data_buf_q[tx_cnt_q[AW-1:0]];
          reply_data_vld_d = 1'b1;
          tx_cnt_d         = tx_cnt_q + ONE_CNT;
        end
      end

      S_DROP: begin
        state_d  = S_IDLE;
        rx_cnt_d = '0;
        tx_cnt_d = '0;
      end

      default: begin
        state_d  = S_IDLE;
        rx_cnt_d = '0;
        tx_cnt_d = '0;
      end
    endcase

    // Closing a reply: strobe the decoded ack, or discard an illegal header.
    if (do_close) begin
      if (close_bad) begin
        state_d = S_DROP;
      end else begin
        state_d         = S_ACK_OUT;
        reply_ack_d     = close_ack;
        reply_ack_vld_d = 1'b1;
      end
    end

    // The error pulse coincides with the single DROP cycle.
    reply_error_d = (state_d == S_DROP);
  end

  // State, counters, buffer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      rx_cnt_q         <= '0;
      tx_cnt_q         <= '0;
      hdr_q            <= '0;
      mode_i2c_q       <= 1'b0;
      for (int i = 0; i < MAX_DATA; i++) begin
        data_buf_q[i] <= 8'h00;
      end
      reply_ack_q      <= 2'b00;
      reply_ack_vld_q  <= 1'b0;
      reply_data_q     <= 8'h00;
      reply_data_vld_q <= 1'b0;
      reply_error_q    <= 1'b0;
      reply_overrun_q  <= 1'b0;
    end else begin
      state_q          <= state_d;
      rx_cnt_q         <= rx_cnt_d;
      tx_cnt_q         <= tx_cnt_d;
      hdr_q            <= hdr_d;
      mode_i2c_q       <= mode_i2c_d;
      data_buf_q       <= data_buf_d;
      reply_ack_q      <= reply_ack_d;
      reply_ack_vld_q  <= reply_ack_vld_d;
      reply_data_q     <= reply_data_d;
      reply_data_vld_q <= reply_data_vld_d;
      reply_error_q    <= reply_error_d;
      reply_overrun_q  <= reply_overrun_d;
    end
  end

  assign reply_ack      = reply_ack_q;
  assign reply_ack_vld  = reply_ack_vld_q;
  assign reply_data     = reply_data_q;
  assign reply_data_vld = reply_data_vld_q;
  assign reply_error    = reply_error_q;
  assign reply_overrun  = reply_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_aux_reply_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_aux_reply_decoder
// Description : Scoreboard bench for aux_reply_decoder. Directed replies plus
//               randomized replies; a reference model predicts each reply's
//               outcome and payload, a monitor compares against DUT strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aux_reply_decoder;

  localparam int MAX_DATA = 16;
  localparam int CW       = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ctrl_tr_vld;
  logic       ctrl_i2c_native;
  logic [7:0] phy_rx_byte;
  logic       phy_rx_vld;
  logic       phy_rx_done;
  logic       phy_rx_err;
  logic [1:0] reply_ack;
  logic       reply_ack_vld;
  logic [7:0] reply_data;
  logic       reply_data_vld;
  logic       reply_error;
  logic       reply_overrun;

  aux_reply_decoder #(.MAX_DATA(MAX_DATA), .CW(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ctrl_tr_vld     (ctrl_tr_vld),
    .ctrl_i2c_native (ctrl_i2c_native),
    .phy_rx_byte     (phy_rx_byte),
    .phy_rx_vld      (phy_rx_vld),
    .phy_rx_done     (phy_rx_done),
    .phy_rx_err      (phy_rx_err),
    .reply_ack       (reply_ack),
    .reply_ack_vld   (reply_ack_vld),
    .reply_data      (reply_data),
    .reply_data_vld  (reply_data_vld),
    .reply_error     (reply_error),
    .reply_overrun   (reply_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [1:0] ack;
    int         ndata;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_data_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         exp_ovr  = 0;
  int         obs_ovr  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: outcome of a whole reply from its byte list.
  // Returns the number of data bytes replayed, or -1 when discarded.
  function automatic int model_reply(input bit i2c, input logic [7:0] bytes[$], input bit err);
    exp_t       e;
    logic [1:0] f;
    logic [7:0] h;
    bit         bad;
    int         n;
    n        = bytes.size();
    e.is_err = 1'b1;
    e.ack    = 2'b00;
    e.ndata  = 0;
    if (!err && n >= 1 && n <= MAX_DATA + 1) begin
      h   = bytes[0];
      f   = (i2c && h[5:4] == 2'b00) ? h[7:6] : h[5:4];
      bad = (f == 2'b11);
`ifdef AUX_REPLY_PAD_CHECK_EN
      if (h[3:0] != 4'h0) bad = 1'b1;
`endif
      if (!bad) begin
        e.is_err = 1'b0;
        e.ack    = f;
        e.ndata  = n - 1;
        for (int i = 1; i < n; i++) exp_data_q.push_back(bytes[i]);
      end
    end
    exp_q.push_back(e);
    return e.is_err ? -1 : e.ndata;
  endfunction

  // Drive one complete reply and wait until the DUT is idle again.
  task automatic run_reply(input bit i2c, input logic [7:0] bytes[$], input bit done_last,
                           input bit err_mid, input int max_gap, input bit ovr);
    int n;
    int nd;
    int k;
    n = bytes.size();
    ctrl_tr_vld     = 1'b1;
    ctrl_i2c_native = i2c;
    tick();
    ctrl_tr_vld     = 1'b0;
    nd = model_reply(i2c, bytes, err_mid);
    if (err_mid) begin
      k = $urandom_range(1, (n > 0) ? n : 1);
      for (int i = 0; i < k && i < n; i++) begin
        phy_rx_vld = 1'b1; phy_rx_byte = bytes[i];
        tick();
        phy_rx_vld = 1'b0;
      end
      phy_rx_err = 1'b1;
      tick();
      phy_rx_err = 1'b0;
      repeat (3) tick();
      return;
    end
    if (n > MAX_DATA + 1) done_last = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat ($urandom_range(0, max_gap)) tick();
      phy_rx_vld  = 1'b1;
      phy_rx_byte = bytes[i];
      phy_rx_done = done_last && (i == n - 1);
      tick();
      phy_rx_vld  = 1'b0;
      phy_rx_done = 1'b0;
    end
    if (n == 0 || !done_last) begin
      repeat ($urandom_range(0, max_gap)) tick();
      phy_rx_done = 1'b1;
      tick();
      phy_rx_done = 1'b0;
    end
    if (nd < 0) begin
      repeat (3) tick();
    end else if (ovr && nd >= 2) begin
      tick();
      phy_rx_vld  = 1'b1;
      phy_rx_byte = 8'($urandom);
      tick();
      phy_rx_vld  = 1'b0;
      exp_ovr++;
      repeat (nd + 2) tick();
    end else begin
      repeat (nd + 3) tick();
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a strobe.
  initial begin : monitor
    int         burst_left;
    exp_t       e;
    logic [7:0] d;
    burst_left = 0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (burst_left > 0) begin
          check("data_vld_in_burst", 32'(reply_data_vld), 32'd1);
          if (exp_data_q.size() > 0) begin
            d = exp_data_q.pop_front();
            check("data_byte", 32'(reply_data), 32'(d));
          end
          burst_left--;
        end else begin
          check("data_vld_outside_burst", 32'(reply_data_vld), 32'd0);
        end
        if (reply_ack_vld === 1'b1 || reply_error === 1'b1) begin
          check("outcome_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (reply_ack_vld === 1'b1) begin
              check("ack_vs_error", 32'(e.is_err), 32'd0);
              check("ack_code", 32'(reply_ack), 32'(e.ack));
              check("ack_err_exclusive", 32'(reply_error), 32'd0);
              burst_left = e.is_err ? 0 : e.ndata;
            end else begin
              check("error_vs_ack", 32'(e.is_err), 32'd1);
            end
          end
        end
        if (reply_overrun === 1'b1) obs_ovr++;
      end
    end
  end

  // Stimulus: reset, directed replies, then randomized replies.
  initial begin : stim
    logic [7:0] b[$];
    int         sel;
    int         n;
    logic [7:0] h;
    rst_n = 1'b0; ctrl_tr_vld = 1'b0; ctrl_i2c_native = 1'b0;
    phy_rx_byte = 8'h00; phy_rx_vld = 1'b0; phy_rx_done = 1'b0; phy_rx_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_reply_ack", 32'(reply_ack), 32'd0);
    check("rst_reply_ack_vld", 32'(reply_ack_vld), 32'd0);
    check("rst_reply_data", 32'(reply_data), 32'd0);
    check("rst_reply_data_vld", 32'(reply_data_vld), 32'd0);
    check("rst_reply_error", 32'(reply_error), 32'd0);
    check("rst_reply_overrun", 32'(reply_overrun), 32'd0);
    rst_n = 1'b1;
    tick();

    b = {8'h00, 8'hA1, 8'hB2, 8'hC3}; run_reply(1'b0, b, 1'b1, 1'b0, 0, 1'b0);
    b = {8'h10, 8'h02};               run_reply(1'b0, b, 1'b0, 1'b0, 0, 1'b0);
    b = {8'h20};                      run_reply(1'b0, b, 1'b0, 1'b0, 0, 1'b0);
    b = {8'h40};                      run_reply(1'b1, b, 1'b0, 1'b0, 0, 1'b0);
    b = {8'h60};                      run_reply(1'b1, b, 1'b1, 1'b0, 0, 1'b0);
    b = {8'hC0};                      run_reply(1'b1, b, 1'b0, 1'b0, 0, 1'b0);
    b = {};                           run_reply(1'b0, b, 1'b0, 1'b0, 0, 1'b0);
    b = {8'h00};
    for (int i = 0; i < MAX_DATA + 1; i++) b.push_back(8'(i + 8'h30));
    run_reply(1'b0, b, 1'b1, 1'b0, 0, 1'b0);
    b = {8'h00};
    for (int i = 0; i < MAX_DATA; i++) b.push_back(8'(8'hE0 - i));
    run_reply(1'b0, b, 1'b1, 1'b0, 0, 1'b0);
    b = {8'h00, 8'h11, 8'h22, 8'h33}; run_reply(1'b0, b, 1'b1, 1'b1, 0, 1'b0);
    b = {8'h00, 8'h5A, 8'h6B, 8'h7C}; run_reply(1'b0, b, 1'b1, 1'b0, 0, 1'b1);
    b = {8'h05, 8'h99};               run_reply(1'b0, b, 1'b1, 1'b0, 0, 1'b0);

    for (int r = 0; r < 150; r++) begin
      sel = $urandom_range(0, 9);
      h   = 8'($urandom);
      if ($urandom_range(0, 1) == 0) h[3:0] = 4'h0;
      b = {h};
      if (sel == 0) begin
        b = {};
      end else if (sel == 1) begin
        for (int i = 0; i < MAX_DATA + 1; i++) b.push_back(8'($urandom));
      end else begin
        n = $urandom_range(0, MAX_DATA);
        for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      end
      run_reply(1'($urandom_range(0, 1)), b, 1'($urandom_range(0, 1)),
                (sel == 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    repeat (10) tick();
    check("outcomes_drained", 32'(exp_q.size()), 32'd0);
    check("data_drained", 32'(exp_data_q.size()), 32'd0);
    check("overrun_count", 32'(obs_ovr), 32'(exp_ovr));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
